// File: rtl/pong_pkg.sv
// Shared geometry constants and game-state encoding for the Pong game engine.
// Positions are 10-bit unsigned pixel coordinates (top-left origin).
package pong_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PADDLE_W  = 10;
  localparam int PADDLE_H  = 80;
  localparam int BALL_SIZE = 10;

  localparam logic [9:0] PADDLE_Y_MAX   = 10'd400;
  localparam logic [9:0] PADDLE_Y_RESET = 10'd200;
  localparam logic [9:0] BALL_X_MIN     = 10'd10;
  localparam logic [9:0] BALL_X_MAX     = 10'd620;
  localparam logic [9:0] BALL_Y_MAX     = 10'd470;
  localparam logic [9:0] CENTER_X       = 10'd315;
  localparam logic [9:0] CENTER_Y       = 10'd235;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } game_state_t;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: 2-flop button synchronizers plus clamped up/down stepping,
// updated once per frame while enabled.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_pulse,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [9:0] y
);

  logic [1:0] up_sync;
  logic [1:0] dn_sync;
  logic [9:0] y_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_dn};
    end
  end

  // Both buttons held cancel each other out; the clamps are written so nothing wraps.
  always_comb begin
    y_next = y;
    if (up_sync[1] && !dn_sync[1]) begin
      y_next = (y < 10'(STEP)) ? 10'd0 : y - 10'(STEP);
    end else if (dn_sync[1] && !up_sync[1]) begin
      y_next = (y + 10'(STEP) > PADDLE_Y_MAX) ? PADDLE_Y_MAX : y + 10'(STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= PADDLE_Y_RESET;
    end else if (frame_pulse && enable) begin
      y <= y_next;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-state engine: paddles, ball motion, wall/paddle bounces and scoring,
// all advanced once per frame_pulse.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_STEP    = 2,
  parameter int PADDLE_STEP  = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_pulse,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] y1,
  output logic [9:0] y2,
  output logic [9:0] xb,
  output logic [9:0] yb,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over
);

  localparam logic [9:0] STEP_B = 10'(BALL_STEP);

  game_state_t state, state_next;
  logic [7:0]  serve_cnt, cnt_next;
  logic [9:0]  xb_next, yb_next;
  logic        dx_right, dxr_next;
  logic        dy_down, dyd_next;
  logic [3:0]  s1_next, s2_next;
  logic        paddle_en;
  logic        left_hit, right_hit;

  pong_paddle #(.STEP(PADDLE_STEP)) u_paddle1 (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse), .enable(paddle_en),
    .btn_up(p1_up), .btn_dn(p1_dn), .y(y1)
  );

  pong_paddle #(.STEP(PADDLE_STEP)) u_paddle2 (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse), .enable(paddle_en),
    .btn_up(p2_up), .btn_dn(p2_dn), .y(y2)
  );

  // Hit tests use the pre-update ball and paddle positions.
  assign left_hit  = (yb + 10'(BALL_SIZE) > y1) && (yb < y1 + 10'(PADDLE_H));
  assign right_hit = (yb + 10'(BALL_SIZE) > y2) && (yb < y2 + 10'(PADDLE_H));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SERVE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = serve_cnt;
    xb_next    = xb;
    yb_next    = yb;
    dxr_next   = dx_right;
    dyd_next   = dy_down;
    s1_next    = score1;
    s2_next    = score2;
    if (frame_pulse) begin
      case (state)
        SERVE: begin
          xb_next = CENTER_X;
          yb_next = CENTER_Y;
          if (serve_cnt == 8'(SERVE_FRAMES - 1)) begin
            cnt_next   = 8'd0;
            state_next = PLAY;
          end else begin
            cnt_next = serve_cnt + 8'd1;
          end
        end
        PLAY: begin
          if (!dy_down && yb < STEP_B) begin
            yb_next  = 10'd0;
            dyd_next = 1'b1;
          end else if (dy_down && yb + STEP_B > BALL_Y_MAX) begin
            yb_next  = BALL_Y_MAX;
            dyd_next = 1'b0;
          end else begin
            yb_next = dy_down ? yb + STEP_B : yb - STEP_B;
          end

          // A miss overrides the vertical result and recentres the ball.
          if (!dx_right && xb <= BALL_X_MIN + STEP_B) begin
            if (left_hit) begin
              xb_next  = BALL_X_MIN;
              dxr_next = 1'b1;
            end else begin
              s2_next    = score2 + 4'd1;
              dxr_next   = 1'b0;
              xb_next    = CENTER_X;
              yb_next    = CENTER_Y;
              dyd_next   = dy_down;
              state_next = (score2 + 4'd1 == 4'(MAX_SCORE)) ? OVER : SERVE;
            end
          end else if (dx_right && xb + STEP_B >= BALL_X_MAX) begin
            if (right_hit) begin
              xb_next  = BALL_X_MAX;
              dxr_next = 1'b0;
            end else begin
              s1_next    = score1 + 4'd1;
              dxr_next   = 1'b1;
              xb_next    = CENTER_X;
              yb_next    = CENTER_Y;
              dyd_next   = dy_down;
              state_next = (score1 + 4'd1 == 4'(MAX_SCORE)) ? OVER : SERVE;
            end
          end else begin
            xb_next = dx_right ? xb + STEP_B : xb - STEP_B;
          end
        end
        OVER: begin
          xb_next = CENTER_X;
          yb_next = CENTER_Y;
        end
        default: begin
          state_next = SERVE;
        end
      endcase
    end
  end

  always_comb begin
    game_over = (state == OVER);
    paddle_en = (state != OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_cnt <= 8'd0;
      xb        <= CENTER_X;
      yb        <= CENTER_Y;
      dx_right  <= 1'b1;
      dy_down   <= 1'b1;
      score1    <= 4'd0;
      score2    <= 4'd0;
    end else begin
      serve_cnt <= cnt_next;
      xb        <= xb_next;
      yb        <= yb_next;
      dx_right  <= dxr_next;
      dy_down   <= dyd_next;
      score1    <= s1_next;
      score2    <= s2_next;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl: serve, wall bounce, paddle
// miss/hit, paddle clamping, game over and asynchronous reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_pulse = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0] y1, y2, xb, yb;
  logic [3:0] score1, score2;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  pong_game_ctrl #(
    .BALL_STEP(2), .PADDLE_STEP(4), .SERVE_FRAMES(60), .MAX_SCORE(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .y1(y1), .y2(y2), .xb(xb), .yb(yb),
    .score1(score1), .score2(score2), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Buttons settle through the synchronizers before any frame is pulsed.
  task automatic applyStimulus(input logic u1, input logic d1, input logic u2,
                               input logic d2, input int frames);
    @(negedge clk);
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    repeat (3) @(negedge clk);
    for (int i = 0; i < frames; i++) begin
      frame_pulse = 1'b1;
      @(negedge clk);
      frame_pulse = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    doReset();
    $display("[TB] reset values");
    checkOutput("rst_y1", y1, 200);
    checkOutput("rst_y2", y2, 200);
    checkOutput("rst_xb", xb, 315);
    checkOutput("rst_yb", yb, 235);
    checkOutput("rst_s1", score1, 0);
    checkOutput("rst_s2", score2, 0);
    checkOutput("rst_over", game_over, 0);

    $display("[TB] serve and first rally");
    applyStimulus(0, 0, 0, 0, 59);
    checkOutput("serve59_xb", xb, 315);
    checkOutput("serve59_yb", yb, 235);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("serve60_xb", xb, 315);
    checkOutput("serve60_yb", yb, 235);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("play1_xb", xb, 317);
    checkOutput("play1_yb", yb, 237);
    applyStimulus(0, 0, 0, 0, 117);
    checkOutput("play118_yb", yb, 470);
    checkOutput("play118_xb", xb, 551);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("play119_yb", yb, 468);
    checkOutput("play119_xb", xb, 553);
    applyStimulus(0, 0, 0, 0, 33);
    checkOutput("play152_xb", xb, 619);
    checkOutput("play152_yb", yb, 402);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("miss1_s1", score1, 1);
    checkOutput("miss1_s2", score2, 0);
    checkOutput("miss1_xb", xb, 315);
    checkOutput("miss1_yb", yb, 235);
    checkOutput("miss1_over", game_over, 0);

    $display("[TB] second rally to game over");
    applyStimulus(0, 0, 0, 0, 61);
    checkOutput("serve2_xb", xb, 317);
    checkOutput("serve2_yb", yb, 233);
    applyStimulus(0, 0, 0, 0, 117);
    checkOutput("top_bounce_yb", yb, 0);
    applyStimulus(0, 0, 0, 0, 34);
    checkOutput("r2_152_xb", xb, 619);
    checkOutput("r2_152_yb", yb, 68);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("over_s1", score1, 2);
    checkOutput("over_flag", game_over, 1);
    checkOutput("over_xb", xb, 315);
    applyStimulus(1, 0, 0, 1, 5);
    checkOutput("frozen_y1", y1, 200);
    checkOutput("frozen_y2", y2, 200);
    checkOutput("frozen_s1", score1, 2);
    checkOutput("frozen_yb", yb, 235);
    checkOutput("frozen_over", game_over, 1);

    $display("[TB] asynchronous reset mid-frame");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("arst_over", game_over, 0);
    checkOutput("arst_s1", score1, 0);
    checkOutput("arst_xb", xb, 315);
    doReset();

    $display("[TB] paddle clamp");
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("clamp_y1_196", y1, 196);
    applyStimulus(1, 0, 0, 0, 49);
    checkOutput("clamp_y1_0", y1, 0);
    applyStimulus(1, 0, 0, 0, 2);
    checkOutput("clamp_y1_hold0", y1, 0);
    applyStimulus(1, 1, 0, 0, 3);
    checkOutput("both_y1", y1, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("down_y1", y1, 4);
    checkOutput("clamp_y2", y2, 200);
    doReset();

    $display("[TB] right paddle hit");
    applyStimulus(0, 0, 0, 1, 50);
    checkOutput("hit_y2_400", y2, 400);
    applyStimulus(0, 0, 0, 1, 11);
    checkOutput("hit_y2_hold", y2, 400);
    checkOutput("hit_play1_xb", xb, 317);
    applyStimulus(0, 0, 0, 1, 151);
    checkOutput("hit_152_xb", xb, 619);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("hit_xb", xb, 620);
    checkOutput("hit_yb", yb, 400);
    checkOutput("hit_s1", score1, 0);
    checkOutput("hit_s2", score2, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("hit_next_xb", xb, 618);
    checkOutput("hit_next_yb", yb, 398);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-state engine for the Pong display path. It produces the paddle and ball positions (`y1`, `y2`, `xb`, `yb`) that the VGA pixel generator latches on `frame_pulse`. Once per frame it reads the player buttons, moves the paddles, advances the ball, resolves wall and paddle bounces, and keeps score. It sits between the board pushbuttons and the pixel generator, on the same pixel clock.

## Interface
- `BALL_STEP`, 2: ball displacement per frame on each axis, in pixels.
- `PADDLE_STEP`, 4: paddle displacement per frame while a button is held.
- `SERVE_FRAMES`, 60: number of frames the ball rests at the centre before each serve.
- `MAX_SCORE`, 9: score value that ends the game.

Ports:
- `clk` in 1: pixel clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_pulse` in 1: one-cycle pulse once per frame from the timing generator.
- `p1_up`, `p1_dn`, `p2_up`, `p2_dn` in 1 each: raw pushbuttons, active-high and asynchronous.
- `y1`, `y2` out 10: top row of the left and right paddles.
- `xb`, `yb` out 10: top-left corner of the ball.
- `score1`, `score2` out 4: player scores.
- `game_over` out 1: high in the OVER state.

## Operation
- Geometry: screen 640x480. Paddles are 10x80; the left paddle spans x 0–9, the right paddle x 630–639. Ball is 10x10.
- Ranges: `y1`/`y2` 0–400, `xb` 10–620 during play, `yb` 0–470.
- Direction state: `dx` (right or left) and `dy` (down or up).
- Buttons: each button passes through a 2-flop synchronizer. The synchronized value is sampled only on a `frame_pulse` cycle.
- Reset values:
  - `y1` = `y2` = 200; `xb` = 315; `yb` = 235.
  - Scores 0; `game_over` 0.
  - State SERVE; serve counter 0; `dx` right; `dy` down; synchronizers 0.
- All updates below happen only on cycles where `frame_pulse` is 1. Every other cycle holds state.
- Paddles, in SERVE and PLAY:
  - up only: y = max(y − `PADDLE_STEP`, 0).
  - down only: y = min(y + `PADDLE_STEP`, 400).
  - both or neither: hold.
- State SERVE:
  - Ball held at (315, 235).
  - Counter increments each frame. When it reaches `SERVE_FRAMES` − 1, clear it and go to PLAY.
- State PLAY, vertical axis:
  - Moving up with `yb` < `BALL_STEP`: `yb` = 0, `dy` becomes down.
  - Moving down with `yb` + `BALL_STEP` > 470: `yb` = 470, `dy` becomes up.
  - Otherwise `yb` ± `BALL_STEP`.
- State PLAY, horizontal axis:
  - Moving left with `xb` ≤ 10 + `BALL_STEP`: a hit is `yb` + 10 > `y1` and `yb` < `y1` + 80.
    - Hit: `xb` = 10, `dx` becomes right.
    - Miss: `score2`++, `dx` becomes left (serve goes toward the player who conceded), ball to centre, go to SERVE.
  - Moving right with `xb` + `BALL_STEP` ≥ 620: mirror of the left case using `y2`; `xb` = 620 on a hit, `score1`++ on a miss, `dx` becomes right.
  - Otherwise `xb` ± `BALL_STEP`.
- Simultaneous events:
  - Both axes are evaluated in the same frame, so a corner bounce reverses both.
  - The hit test uses the pre-update `yb`, `y1` and `y2`.
  - On a miss the vertical result is discarded.
- State OVER:
  - Entered instead of SERVE when the incremented score equals `MAX_SCORE`.
  - Ball at centre; paddles and scores frozen; `game_over` = 1.
  - Left only by `rst`.
- Arithmetic: 10-bit unsigned. Write comparisons as the additions shown so nothing can underflow.

## Timing
- All outputs are registered and change the cycle after `frame_pulse`.
- The pixel generator latches on the `frame_pulse` cycle itself. Displayed positions therefore lag the game state by exactly one frame.
- Button latency: 2 cycles of synchronizer, then the next `frame_pulse`.
- `rst` asserted mid-frame or mid-serve forces every reset value immediately.
- After `rst` deasserts, the first `frame_pulse` starts SERVE counting.
- Back-to-back `frame_pulse` cycles each count as a separate frame. Enforcing single-cycle pulses is the timing generator's job.

## Structure
- Package `pong_pkg` holds:
  - Constants: `SCREEN_W`, `SCREEN_H`, `PADDLE_W`, `PADDLE_H`, `BALL_SIZE`, `PADDLE_Y_MAX` (400), `BALL_X_MIN` (10), `BALL_X_MAX` (620), `BALL_Y_MAX` (470), `CENTER_X`, `CENTER_Y`.
  - The state encoding: SERVE, PLAY, OVER.
- Sub-module `pong_paddle`, instantiated twice: synchronizer plus clamped up/down stepping, with reset value 200.

## Test plan
- **Serve:** reset, then 60 pulses → state PLAY. The next pulse gives `xb` = 317, `yb` = 237; earlier pulses keep (315, 235).
- **Wall bounce:** continue from the serve test with no buttons → after the 118th PLAY frame `yb` = 470 and the next frame `yb` = 468.
- **Right-paddle miss:** continue with no buttons → at the frame where `xb` = 619 the ball misses `y2` = 200. Result: `score1` = 1, ball (315, 235), SERVE, next serve moves right.
- **Right-paddle hit:** hold `p2_dn` from reset → `y2` reaches 400 after 50 frames and stays. At the right-edge frame `xb` = 620, `dx` becomes left, scores stay 0.
- **Paddle clamp:**
  - Hold `p1_up` → `y1` goes 200, 196, … down to 0 and stays at 0.
  - Hold `p1_up` and `p1_dn` together → `y1` unchanged.
- **Game over and reset:** with `MAX_SCORE` = 2, two right-side misses → `game_over` = 1; further pulses and buttons change nothing. Assert `rst` mid-frame → all reset values appear without a clock edge.
